// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: receiver state
// encoding, legal parameter ranges and the parity helper.
package uart_pkg;

  localparam int DATA_BITS_MIN  = 5;
  localparam int DATA_BITS_MAX  = 9;
  localparam int OVERSAMPLE_MIN = 8;
  localparam int OVERSAMPLE_MAX = 32;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_e;

  // Expected parity bit for a zero-extended data word; odd=1 inverts it.
  function automatic logic calc_parity(input logic [DATA_BITS_MAX-1:0] data,
                                       input logic                     odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops
// reset to 1 so an idle-high line never produces a false start edge.
module uart_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] sync_ff;

  // Shift the raw line through two flops, resetting to the idle level.
  always_ff @(posedge i_clk) begin
    if (i_rst) sync_ff <= 2'b11;
    else       sync_ff <= {sync_ff[0], i_d};
  end

  assign o_q = sync_ff[1];

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with a valid/ready output register, stop-bit
// framing check, break handling and a sticky overrun flag.
// Optional feature: define UART_RX_PARITY_EN to insert a parity bit after
// the data bits (even parity, or odd with PARITY_ODD=1).
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_in,
  input  logic                 i_sample_tick,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = RX_IDLE;
  localparam logic [2:0] S_START  = RX_START;
  localparam logic [2:0] S_DATA   = RX_DATA;
  localparam logic [2:0] S_PARITY = RX_PARITY;
  localparam logic [2:0] S_STOP   = RX_STOP;
  localparam logic [2:0] S_BREAK  = RX_BREAK;

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
      OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX ||
      (OVERSAMPLE % 2) != 0 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_rx_ovs: parameter out of legal range");
  end

  logic                 rx_s;
  logic [2:0]           state;
  logic [TW-1:0]        tick_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 stop_err;
  logic                 done;
  logic [DATA_BITS-1:0] done_data;
  logic                 done_ferr;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
  logic                 done_perr;
  logic                 perr_q;
`endif

  uart_sync2 u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_in),
    .o_q   (rx_s)
  );

  // Frame FSM: locate mid-bit points with the tick counter, shift data in
  // LSB first, check stop bits and hand a finished word to the output stage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      stop_err  <= 1'b0;
      done      <= 1'b0;
      done_data <= '0;
      done_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit   <= 1'b0;
      done_perr <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state    <= S_START;
            tick_cnt <= '0;
          end
        end
        S_START: begin
          if (i_sample_tick) begin
            if (tick_cnt == MID_TICK) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rx_s ? S_IDLE : S_DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (i_sample_tick) begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt <= '0;
              shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
              if (bit_cnt == LAST_DATA) begin
                bit_cnt  <= '0;
                stop_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
                state    <= S_PARITY;
`else
                state    <= S_STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (i_sample_tick) begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt <= '0;
              par_bit  <= rx_s;
              state    <= S_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`endif
        S_STOP: begin
          if (i_sample_tick) begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt <= '0;
              if (bit_cnt == LAST_STOP) begin
                bit_cnt   <= '0;
                done      <= 1'b1;
                done_data <= shreg;
                done_ferr <= stop_err | ~rx_s;
`ifdef UART_RX_PARITY_EN
                done_perr <= calc_parity(DATA_BITS_MAX'(shreg), 1'(PARITY_ODD)) != par_bit;
`endif
                state     <= rx_s ? S_IDLE : S_BREAK;
              end else begin
                bit_cnt  <= bit_cnt + 1'b1;
                stop_err <= stop_err | ~rx_s;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        S_BREAK: begin
          if (i_sample_tick && rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output register: load a finished word when the slot is free or being
  // emptied this cycle, otherwise drop it and flag the overrun.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q      <= 1'b0;
`endif
    end else if (done) begin
      if (!o_valid || i_ready) begin
        o_data      <= done_data;
        o_valid     <= 1'b1;
        o_frame_err <= done_ferr;
`ifdef UART_RX_PARITY_EN
        perr_q      <= done_perr;
`endif
      end else begin
        o_overrun <= 1'b1;
      end
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: 8 data bits, 16x oversampling, one stop
// bit, sample tick every second clock (one bit period = 32 clocks).
module tb_uart_rx_ovs;
  import uart_pkg::*;

  localparam int BIT_CLKS = 32;

  logic       i_clk;
  logic       i_rst;
  logic       i_in;
  logic       i_sample_tick;
  logic       i_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_parity_err;
  logic       o_overrun;

  int         checkCount = 0;
  int         passCount  = 0;
  int         validRises = 0;
  int         validCycles = 0;
  int         hsCount = 0;
  logic       prevValid = 1'b0;
  logic [7:0] hsData = 8'h00;
  logic       hsFerr = 1'b0;
  logic       hsPerr = 1'b0;
  int         r0, c0, h0;

  uart_rx_ovs #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16),
    .STOP_BITS  (1),
    .PARITY_ODD (0)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_in          (i_in),
    .i_sample_tick (i_sample_tick),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_frame_err   (o_frame_err),
    .o_parity_err  (o_parity_err),
    .o_overrun     (o_overrun)
  );

  // 100 MHz clock
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Sample tick: high for one clock out of every two
  initial begin
    i_sample_tick = 1'b0;
    forever begin
      @(negedge i_clk);
      i_sample_tick = ~i_sample_tick;
    end
  end

  // Observe the output port on the falling edge: count valid pulses and
  // record the word and flags presented at each handshake
  always @(negedge i_clk) begin
    if (o_valid) validCycles = validCycles + 1;
    if (o_valid && !prevValid) validRises = validRises + 1;
    if (o_valid && i_ready) begin
      hsCount = hsCount + 1;
      hsData  = o_data;
      hsFerr  = o_frame_err;
      hsPerr  = o_parity_err;
    end
    prevValid = o_valid;
  end

  // Advance n clocks, leaving inputs to change 1 ns after the rising edge
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount = checkCount + 1;
    if (actual === expected) passCount = passCount + 1;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Hold one bit on the line for a full bit period
  task automatic sendBit(input logic b);
    i_in = b;
    cyc(BIT_CLKS);
  endtask

  // Send a complete frame; the line is left at the stop-bit level
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                               input logic parityBit);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(data[i]);
`ifdef UART_RX_PARITY_EN
    sendBit(parityBit);
`else
    if (parityBit === 1'bx) $display("[TB] parity argument undefined");
`endif
    sendBit(stopBit);
  endtask

  initial begin
    i_rst   = 1'b1;
    i_in    = 1'b1;
    i_ready = 1'b1;
    cyc(4);
    i_rst = 1'b0;
    cyc(2);

    // Reset state
    checkOutput("rst_valid",    32'(o_valid),      32'h0);
    checkOutput("rst_data",     32'(o_data),       32'h0);
    checkOutput("rst_ferr",     32'(o_frame_err),  32'h0);
    checkOutput("rst_perr",     32'(o_parity_err), 32'h0);
    checkOutput("rst_overrun",  32'(o_overrun),    32'h0);
    checkOutput("rst_state",    32'(dut.state),    32'(RX_IDLE));

    // Clean frame 0xA5 with consumer ready: single-cycle valid pulse
    r0 = validRises; c0 = validCycles;
    applyStimulus(8'hA5, 1'b1, 1'b0);
    cyc(BIT_CLKS);
    checkOutput("a5_rises",  32'(validRises - r0),  32'd1);
    checkOutput("a5_cycles", 32'(validCycles - c0), 32'd1);
    checkOutput("a5_data",   32'(hsData), 32'hA5);
    checkOutput("a5_ferr",   32'(hsFerr), 32'h0);
    checkOutput("a5_perr",   32'(hsPerr), 32'h0);

    // Four-tick low glitch on an idle line is rejected
    r0 = validRises;
    i_in = 1'b0;
    cyc(8);
    i_in = 1'b1;
    cyc(2 * BIT_CLKS);
    checkOutput("glitch_rises", 32'(validRises - r0), 32'd0);
    checkOutput("glitch_state", 32'(dut.state), 32'(RX_IDLE));

    // Two frames with consumer stalled: second is dropped, overrun set
    r0 = validRises;
    i_ready = 1'b0;
    applyStimulus(8'h31, 1'b1, 1'b1);
    applyStimulus(8'h32, 1'b1, 1'b1);
    cyc(BIT_CLKS);
    checkOutput("ovr_valid",   32'(o_valid),   32'h1);
    checkOutput("ovr_data",    32'(o_data),    32'h31);
    checkOutput("ovr_flag",    32'(o_overrun), 32'h1);
    checkOutput("ovr_rises",   32'(validRises - r0), 32'd1);
    h0 = hsCount;
    i_ready = 1'b1;
    cyc(2);
    checkOutput("ovr_hs_count", 32'(hsCount - h0), 32'd1);
    checkOutput("ovr_hs_data",  32'(hsData),  32'h31);
    checkOutput("ovr_valid_lo", 32'(o_valid), 32'h0);
    checkOutput("ovr_sticky",   32'(o_overrun), 32'h1);

    // 0x55 with a low stop bit, then line held low for three bit times
    r0 = validRises;
    applyStimulus(8'h55, 1'b0, 1'b0);
    cyc(3 * BIT_CLKS);
    checkOutput("ferr_rises", 32'(validRises - r0), 32'd1);
    checkOutput("ferr_data",  32'(hsData), 32'h55);
    checkOutput("ferr_hs",    32'(hsFerr), 32'h1);
    checkOutput("ferr_port",  32'(o_frame_err), 32'h1);
    checkOutput("ferr_break", 32'(dut.state), 32'(RX_BREAK));
    i_in = 1'b1;
    cyc(2 * BIT_CLKS);
    checkOutput("brk_rises", 32'(validRises - r0), 32'd1);
    checkOutput("brk_idle",  32'(dut.state), 32'(RX_IDLE));
    applyStimulus(8'h3C, 1'b1, 1'b0);
    cyc(BIT_CLKS);
    checkOutput("post_brk_rises", 32'(validRises - r0), 32'd2);
    checkOutput("post_brk_data",  32'(hsData), 32'h3C);
    checkOutput("post_brk_ferr",  32'(hsFerr), 32'h0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so even parity requires a 1 on the line
    r0 = validRises;
    applyStimulus(8'h07, 1'b1, 1'b0);
    cyc(BIT_CLKS);
    checkOutput("par_bad_data", 32'(hsData), 32'h07);
    checkOutput("par_bad_err",  32'(hsPerr), 32'h1);
    applyStimulus(8'h07, 1'b1, 1'b1);
    cyc(BIT_CLKS);
    checkOutput("par_good_err",   32'(hsPerr), 32'h0);
    checkOutput("par_good_rises", 32'(validRises - r0), 32'd2);
`endif

    // Reset in the middle of data bit 4 of 0xFF, then a clean 0x12
    r0 = validRises;
    i_in = 1'b0;
    cyc(BIT_CLKS);
    i_in = 1'b1;
    cyc(4 * BIT_CLKS + BIT_CLKS / 2);
    i_rst = 1'b1;
    cyc(2);
    i_rst = 1'b0;
    cyc(1);
    checkOutput("midrst_state",   32'(dut.state), 32'(RX_IDLE));
    checkOutput("midrst_valid",   32'(o_valid),   32'h0);
    checkOutput("midrst_overrun", 32'(o_overrun), 32'h0);
    cyc(4 * BIT_CLKS);
    applyStimulus(8'h12, 1'b1, 1'b0);
    cyc(BIT_CLKS);
    checkOutput("midrst_rises", 32'(validRises - r0), 32'd1);
    checkOutput("midrst_data",  32'(hsData), 32'h12);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/uart_rx_ovs.md
UART_RX_OVS -- requirements
Module: uart_rx_ovs

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (legal range 5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, number of i_sample_tick pulses per bit period (even, legal range 8..32).
REQ-003 SHALL have parameter STOP_BITS, default 1, number of stop bits checked (1 or 2).
REQ-004 SHALL have parameter PARITY_ODD, default 0; 0 selects even parity, 1 selects odd parity (effective only with UART_RX_PARITY_EN).
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port i_in, input, 1 bit: asynchronous serial line, idle high.
REQ-008 SHALL have port i_sample_tick, input, 1 bit: one-cycle strobe at OVERSAMPLE times the baud rate.
REQ-009 SHALL have port o_data, output, DATA_BITS bits: received word, LSB first on the line.
REQ-010 SHALL have port o_valid, output, 1 bit: o_data is held stable while this is high.
REQ-011 SHALL have port i_ready, input, 1 bit: consumer accepts the word when o_valid and i_ready are both high in the same cycle.
REQ-012 SHALL have port o_frame_err, output, 1 bit: stop-bit error status for the word in o_data.
REQ-013 SHALL have port o_parity_err, output, 1 bit: parity error status for the word in o_data.
REQ-014 SHALL have port o_overrun, output, 1 bit: sticky flag that a completed frame was dropped.

Function
REQ-015 SHALL pass i_in through a 2-flop synchronizer; all decisions use the synchronized line.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP and BREAK; the tick counter and bit counter advance only on i_sample_tick.
REQ-017 In IDLE, a synchronized low SHALL move the block to START and clear the tick counter.
REQ-018 In START, the line SHALL be sampled at tick OVERSAMPLE/2-1: low proceeds to DATA; high is a glitch and returns to IDLE with no output.
REQ-019 In DATA, one bit SHALL be sampled every OVERSAMPLE ticks, at mid-bit, shifting LSB first; after DATA_BITS samples the block goes to PARITY if enabled, otherwise to STOP.
REQ-020 In STOP, each of the STOP_BITS stop bits SHALL be sampled at mid-bit; any low sample sets the frame error for that word.
REQ-021 Frame completion SHALL occur at the mid-point of the last stop bit; on the next clock, o_data, o_frame_err and o_parity_err update and o_valid rises.
REQ-022 o_valid SHALL stay high until the handshake cycle and fall on the following edge.
REQ-023 If a frame completes while o_valid is high and i_ready is low, the new word SHALL be discarded, the held word retained and o_overrun set.
REQ-024 If a frame completes in the same cycle as the handshake, the new word SHALL be loaded and o_valid stays high, with no overrun.
REQ-025 o_overrun SHALL clear only on reset.
REQ-026 On a frame error with the line low, the block SHALL enter BREAK and return to IDLE only after the synchronized line is high for one full sample tick.
REQ-027 Reception SHALL continue independently of the output handshake; no frames are lost while the output is idle.

Reset
REQ-028 On reset, state SHALL be IDLE, counters 0, synchronizer flops 1, o_data 0, o_valid 0, o_frame_err 0, o_parity_err 0 and o_overrun 0.
REQ-029 A reset asserted mid-frame SHALL abandon the frame with no output; the next start edge is detected normally.

Configuration
REQ-030 Macro UART_RX_PARITY_EN defined SHALL insert the PARITY state: one bit sampled at mid-bit and compared with the XOR of the data bits (inverted when PARITY_ODD=1); a mismatch sets o_parity_err.
REQ-031 Macro UART_RX_PARITY_EN undefined SHALL remove the PARITY state and tie o_parity_err to 0.

Structure
REQ-032 Package uart_pkg SHALL hold the rx state enum, the parity-compute function and the legal-range constants for DATA_BITS and OVERSAMPLE.
REQ-033 The synchronizer SHALL be sub-module uart_sync2, a 2-flop synchronizer with reset value 1.

Verification
REQ-034 The bench SHALL check: OVERSAMPLE=16, DATA_BITS=8, frame 0xA5 with i_ready high -> o_valid pulses for exactly 1 cycle with o_data=0xA5 and both error flags 0.
REQ-035 The bench SHALL check: a 4-tick low glitch on idle i_in -> no o_valid and state back in IDLE.
REQ-036 The bench SHALL check: frames 0x31 then 0x32 with i_ready low -> o_data stays 0x31 and o_overrun=1; after i_ready goes high, the 0x31 handshake completes.
REQ-037 The bench SHALL check: 0x55 with the stop bit low, then the line held low for 3 bit times -> o_frame_err=1 and no further o_valid until the line is high and a new start bit arrives.
REQ-038 The bench SHALL check, with UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 with parity bit 0 -> o_parity_err=1; the same word with parity bit 1 -> o_parity_err=0.
REQ-039 The bench SHALL check: reset asserted during data bit 4 of 0xFF, then frame 0x12 -> o_valid only once, with o_data=0x12.
